// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
// Round-robin front end that shares one spi_master between several command
// sources. The granted requester's operands are latched at grant, the
// master's busy handshake is tracked, and a one-cycle done (plus error on a
// start timeout) is returned to the owner.

module spi_master_arbiter #(
    parameter int REQUESTERS    = 2,
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 15,
    parameter int START_TIMEOUT = 64
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [REQUESTERS-1:0]               request,
    input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] request_address,
    input  logic [REQUESTERS*DATA_WIDTH-1:0]    request_data,
    input  logic [REQUESTERS-1:0]               request_read_write,
    output logic [REQUESTERS-1:0]               grant,
    output logic [REQUESTERS-1:0]               done,
    output logic                                error,
    output logic [DATA_WIDTH-1:0]               response_data,
    output logic                                spi_enable,
    output logic [ADDRESS_WIDTH-1:0]            spi_address,
    output logic [DATA_WIDTH-1:0]               spi_data,
    output logic                                spi_read_write,
    input  logic                                spi_busy,
    input  logic [DATA_WIDTH-1:0]               spi_read_data,
    input  logic                                spi_read_data_valid
);

    localparam int IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int CW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACTIVE,
        COMPLETE
    } state_t;

    state_t                    state_q;
    logic [IW-1:0]             last_grant_q;
    logic [CW-1:0]             count_q;
    logic [REQUESTERS-1:0]     grant_q;
    logic [REQUESTERS-1:0]     done_q;
    logic                      error_q;
    logic [DATA_WIDTH-1:0]     response_q;
    logic                      enable_q;
    logic [ADDRESS_WIDTH-1:0]  address_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      read_write_q;

    // Round-robin winner selection and operand mux for the next grant
    logic [IW-1:0]             winner_d;
    logic [IW-1:0]             cand;
    logic                      found;
    logic [REQUESTERS-1:0]     grant_d;
    logic [ADDRESS_WIDTH-1:0]  address_d;
    logic [DATA_WIDTH-1:0]     data_d;
    logic                      read_write_d;

    // Search from last_grant+1, wrapping, so the previous owner is considered last
    always_comb begin
        winner_d = last_grant_q;
        cand     = '0;
        found    = 1'b0;
        for (int unsigned k = 0; k < REQUESTERS; k++) begin
            cand = IW'((32'(last_grant_q) + k + 32'd1) % REQUESTERS);
            if (!found && request[cand]) begin
                found    = 1'b1;
                winner_d = cand;
            end
        end
    end

    // Decode the winner into a one-hot grant and pick its operands
    always_comb begin
        grant_d      = '0;
        address_d    = '0;
        data_d       = '0;
        read_write_d = 1'b0;
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            if (winner_d == IW'(i)) begin
                grant_d[i]   = 1'b1;
                address_d    = request_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                data_d       = request_data[i*DATA_WIDTH +: DATA_WIDTH];
                read_write_d = request_read_write[i];
            end
        end
    end

    // Arbitration / transaction FSM with all outputs registered
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(REQUESTERS - 1);
            count_q      <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            error_q      <= 1'b0;
            response_q   <= '0;
            enable_q     <= 1'b0;
            address_q    <= '0;
            data_q       <= '0;
            read_write_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q      <= grant_d;
                        last_grant_q <= winner_d;
                        address_q    <= address_d;
                        data_q       <= data_d;
                        read_write_q <= read_write_d;
                        enable_q     <= 1'b1;
                        count_q      <= '0;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // busy takes priority over a coincident timeout expiry
                    if (spi_busy) begin
                        enable_q <= 1'b0;
                        state_q  <= ACTIVE;
                    end else if (count_q == CW'(START_TIMEOUT - 1)) begin
                        enable_q <= 1'b0;
                        error_q  <= 1'b1;
                        done_q   <= grant_q;
                        state_q  <= COMPLETE;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (read_write_q && spi_read_data_valid) begin
                        response_q <= spi_read_data;
                    end
                    if (!spi_busy) begin
                        done_q  <= grant_q;
                        state_q <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    grant_q <= '0;
                    done_q  <= '0;
                    error_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant          = grant_q;
    assign done           = done_q;
    assign error          = error_q;
    assign response_data  = response_q;
    assign spi_enable     = enable_q;
    assign spi_address    = address_q;
    assign spi_data       = data_q;
    assign spi_read_write = read_write_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: two requesters, START_TIMEOUT=8,
// with the spi_master handshake driven by hand from the stimulus sequence.

module tb_spi_master_arbiter;

    localparam int REQ = 2;
    localparam int DW  = 16;
    localparam int AW  = 15;
    localparam int TO  = 8;

    logic               clock;
    logic               reset_n;
    logic [REQ-1:0]     request;
    logic [REQ*AW-1:0]  request_address;
    logic [REQ*DW-1:0]  request_data;
    logic [REQ-1:0]     request_read_write;
    logic [REQ-1:0]     grant;
    logic [REQ-1:0]     done;
    logic               error;
    logic [DW-1:0]      response_data;
    logic               spi_enable;
    logic [AW-1:0]      spi_address;
    logic [DW-1:0]      spi_data;
    logic               spi_read_write;
    logic               spi_busy;
    logic [DW-1:0]      spi_read_data;
    logic               spi_read_data_valid;

    int errors = 0;
    int checks = 0;

    spi_master_arbiter #(
        .REQUESTERS   (REQ),
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .START_TIMEOUT(TO)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .request            (request),
        .request_address    (request_address),
        .request_data       (request_data),
        .request_read_write (request_read_write),
        .grant              (grant),
        .done               (done),
        .error              (error),
        .response_data      (response_data),
        .spi_enable         (spi_enable),
        .spi_address        (spi_address),
        .spi_data           (spi_data),
        .spi_read_write     (spi_read_write),
        .spi_busy           (spi_busy),
        .spi_read_data      (spi_read_data),
        .spi_read_data_valid(spi_read_data_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one cycle; inputs change and outputs are sampled at the falling edge
    task automatic step();
        @(negedge clock);
    endtask

    // slave side of one transaction, entered on the cycle the grant is visible
    task automatic serve(input logic [REQ-1:0] owner, input logic [DW-1:0] rd);
        spi_busy = 1'b1;
        step();
        chk("en_drop", spi_enable, 1'b0);
        chk("grant_active", grant, owner);
        chk("done_active", done, '0);
        step();
        step();
        spi_read_data       = rd;
        spi_read_data_valid = 1'b1;
        step();
        spi_read_data_valid = 1'b0;
        spi_busy            = 1'b0;
        step();
        chk("done_pulse", done, owner);
        chk("error_ok", error, 1'b0);
        chk("grant_held", grant, owner);
        step();
        chk("done_clear", done, '0);
        chk("grant_clear", grant, '0);
    endtask

    initial begin
        reset_n             = 1'b0;
        request             = '0;
        request_address     = '0;
        request_data        = '0;
        request_read_write  = '0;
        spi_busy            = 1'b0;
        spi_read_data       = '0;
        spi_read_data_valid = 1'b0;
        step();
        step();

        // reset values
        chk("rst_grant", grant, '0);
        chk("rst_done", done, '0);
        chk("rst_error", error, 1'b0);
        chk("rst_en", spi_enable, 1'b0);
        chk("rst_rw", spi_read_write, 1'b0);
        chk("rst_addr", spi_address, '0);
        chk("rst_data", spi_data, '0);
        chk("rst_resp", response_data, '0);
        reset_n = 1'b1;
        step();

        // single read from requester 0, request withdrawn one cycle after grant
        request_address[0 +: AW] = 15'h1111;
        request_read_write[0]    = 1'b1;
        request[0]               = 1'b1;
        step();
        chk("t1_grant", grant, 2'b01);
        chk("t1_en", spi_enable, 1'b1);
        chk("t1_addr", spi_address, 15'h1111);
        chk("t1_rw", spi_read_write, 1'b1);
        request[0]               = 1'b0;
        request_address[0 +: AW] = 15'h7777;
        step();
        chk("t1_en_wait", spi_enable, 1'b1);
        chk("t1_addr_hold", spi_address, 15'h1111);
        serve(2'b01, 16'hC3D2);
        chk("t1_resp", response_data, 16'hC3D2);

        // restore reset priority, then alternate between two held requests
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        request_address[0 +: AW]  = 15'h0100;
        request_read_write[0]     = 1'b1;
        request_address[AW +: AW] = 15'h0200;
        request_data[DW +: DW]    = 16'hBEEF;
        request_read_write[1]     = 1'b0;
        request                   = 2'b11;
        step();
        chk("t2_g0", grant, 2'b01);
        chk("t2_addr0", spi_address, 15'h0100);
        serve(2'b01, 16'h1234);
        chk("t2_resp0", response_data, 16'h1234);
        step();
        chk("t2_g1", grant, 2'b10);
        chk("t2_data1", spi_data, 16'hBEEF);
        chk("t2_rw1", spi_read_write, 1'b0);
        serve(2'b10, 16'hFFFF);
        chk("t2_resp1", response_data, 16'h1234);
        step();
        chk("t2_g2", grant, 2'b01);
        serve(2'b01, 16'h5678);
        chk("t2_resp2", response_data, 16'h5678);
        step();
        chk("t2_g3", grant, 2'b10);
        serve(2'b10, 16'h0F0F);
        chk("t2_resp3", response_data, 16'h5678);
        request = 2'b00;

        // requester 1 writes A5A5 to 0x0022 and reads it back
        request_address[AW +: AW] = 15'h0022;
        request_data[DW +: DW]    = 16'hA5A5;
        request_read_write[1]     = 1'b0;
        request                   = 2'b10;
        step();
        chk("t3_wgrant", grant, 2'b10);
        chk("t3_waddr", spi_address, 15'h0022);
        chk("t3_wdata", spi_data, 16'hA5A5);
        chk("t3_wrw", spi_read_write, 1'b0);
        serve(2'b10, 16'h0000);
        chk("t3_wresp", response_data, 16'h5678);
        request_read_write[1] = 1'b1;
        step();
        chk("t3_rgrant", grant, 2'b10);
        chk("t3_rrw", spi_read_write, 1'b1);
        request = 2'b00;
        serve(2'b10, 16'hA5A5);
        chk("t3_rresp", response_data, 16'hA5A5);

        // start timeout: busy never rises
        request_address[0 +: AW] = 15'h0033;
        request_read_write[0]    = 1'b0;
        request                  = 2'b01;
        step();
        chk("t4_grant", grant, 2'b01);
        chk("t4_en1", spi_enable, 1'b1);
        request = 2'b00;
        for (int i = 2; i <= TO; i++) begin
            step();
            chk($sformatf("t4_en%0d", i), spi_enable, 1'b1);
            chk($sformatf("t4_nodone%0d", i), done, '0);
        end
        step();
        chk("t4_en_off", spi_enable, 1'b0);
        chk("t4_done", done, 2'b01);
        chk("t4_error", error, 1'b1);
        step();
        chk("t4_done_clr", done, '0);
        chk("t4_error_clr", error, 1'b0);
        chk("t4_grant_clr", grant, '0);

        // busy rising on the expiry cycle wins over the timeout
        request = 2'b01;
        step();
        chk("t4b_grant", grant, 2'b01);
        request = 2'b00;
        for (int i = 2; i <= TO; i++) begin
            step();
        end
        chk("t4b_en_last", spi_enable, 1'b1);
        serve(2'b01, 16'h9999);

        // busy seen while idle is ignored
        spi_busy = 1'b1;
        step();
        chk("idle_busy_grant", grant, '0);
        chk("idle_busy_en", spi_enable, 1'b0);
        spi_busy = 1'b0;

        // reset during ACTIVE abandons the transaction
        request_address[0 +: AW] = 15'h0044;
        request_read_write[0]    = 1'b1;
        request                  = 2'b01;
        step();
        chk("t5_grant", grant, 2'b01);
        request  = 2'b00;
        spi_busy = 1'b1;
        step();
        step();
        reset_n = 1'b0;
        step();
        chk("t5_grant_rst", grant, '0);
        chk("t5_done_rst", done, '0);
        chk("t5_en_rst", spi_enable, 1'b0);
        chk("t5_addr_rst", spi_address, '0);
        chk("t5_resp_rst", response_data, '0);
        reset_n  = 1'b1;
        spi_busy = 1'b0;
        step();
        chk("t5_no_done", done, '0);
        request = 2'b11;
        step();
        chk("t5_first", grant, 2'b01);
        request = 2'b00;
        serve(2'b01, 16'h4242);
        chk("t5_resp", response_data, 16'h4242);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
